// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Holds the FSM state encoding, funct3 size codes and the access legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 1 when the access is misaligned, has an unknown size code, or is an unsigned store.
  function automatic logic access_bad(input logic [2:0] f3, input logic is_store,
                                      input logic [1:0] a_lo);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:  bad = 1'b0;
      F3_H:  bad = a_lo[0];
      F3_W:  bad = (a_lo != 2'b00);
      F3_BU: bad = is_store;
      F3_HU: bad = is_store | a_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/half lane logic: extracts and extends a load lane from a memory word,
// and merges right-aligned store data into the addressed lane(s) of a word.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] i_word,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [1:0]        i_addr_lo,
  input  logic [2:0]        i_funct3,
  output logic [DWIDTH-1:0] o_load,
  output logic [DWIDTH-1:0] o_merged
);

  logic [4:0]        w_shamt;
  logic [DWIDTH-1:0] w_shifted;
  logic [DWIDTH-1:0] w_wshift;
  logic [DWIDTH-1:0] w_mask;

  assign w_shamt   = {i_addr_lo, 3'b000};
  assign w_shifted = i_word >> w_shamt;
  assign w_wshift  = i_wdata << w_shamt;

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:  o_load = {{(DWIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_H:  o_load = {{(DWIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_BU: o_load = {{(DWIDTH-8){1'b0}}, w_shifted[7:0]};
      F3_HU: o_load = {{(DWIDTH-16){1'b0}}, w_shifted[15:0]};
      default: o_load = i_word;
    endcase
  end

  // A zero mask leaves the word untouched, so full-word codes pass straight through.
  always_comb begin
    w_mask = '0;
    case (i_funct3)
      F3_B:    w_mask = DWIDTH'(8'hFF) << w_shamt;
      F3_H:    w_mask = DWIDTH'(16'hFFFF) << w_shamt;
      default: w_mask = '0;
    endcase
  end

  assign o_merged = (i_word & ~w_mask) | (w_wshift & w_mask);

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between a core and a word-wide memory with combinational read.
// Handshake: req is sampled only in IDLE; ready is a single-cycle completion pulse, with rdata/err valid while it is high.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DWIDTH-1:0] wdata,
  output logic              ready,
  output logic [DWIDTH-1:0] rdata,
  output logic              err,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_d,
  output logic              mem_wen,
  input  logic [DWIDTH-1:0] mem_q,
  output lsu_state_e        o_dbg_state
);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [AWIDTH-1:0] r_addr;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [DWIDTH-1:0] r_wdata;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_err;
  logic              w_bad;
  logic              w_accept;
  logic [DWIDTH-1:0] w_load;
  logic [DWIDTH-1:0] w_merged;

  assign w_bad    = access_bad(funct3, we, addr[1:0]);
  assign w_accept = (r_state == IDLE) && req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_bad)             w_next = DONE;
          else if (!we)          w_next = READ;
          else if (funct3 == F3_W) w_next = WRITE;
          else                   w_next = READ;
        end
      end
      READ:    w_next = r_we ? WRITE : DONE;
      WRITE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_wdata holds the store data, then the merged word for sub-word stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_f3    <= F3_W;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr;
      r_we    <= we;
      r_f3    <= funct3;
      r_wdata <= wdata;
      r_rdata <= '0;
      r_err   <= w_bad;
    end else if (r_state == READ) begin
      if (r_we) r_wdata <= w_merged;
      else      r_rdata <= w_load;
    end
  end

  lsu_lane #(.DWIDTH(DWIDTH)) u_lane (
    .i_word    (mem_q),
    .i_wdata   (r_wdata),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_f3),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  // Stores complete in the write cycle itself; loads and errors complete in DONE.
  assign ready       = (r_state == WRITE) || ((r_state == DONE) && (!r_we || r_err));
  assign rdata       = r_rdata;
  assign err         = r_err;
  assign mem_wen     = (r_state == WRITE);
  assign mem_addr    = {r_addr[AWIDTH-1:2], 2'b00};
  assign mem_d       = r_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a small word-memory model.
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_d;
  logic        mem_wen;
  logic [31:0] mem_q;
  lsu_state_e  dbg_state;

  logic [31:0] mem [0:15];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .funct3(funct3),
    .wdata(wdata), .ready(ready), .rdata(rdata), .err(err), .mem_addr(mem_addr),
    .mem_d(mem_d), .mem_wen(mem_wen), .mem_q(mem_q), .o_dbg_state(dbg_state)
  );

  assign mem_q = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_wen) mem[mem_addr[5:2]] <= mem_d;

  // Issue one access and observe it until the unit returns to IDLE (bounded).
  task automatic do_access(input logic i_we, input logic [31:0] i_addr, input logic [2:0] i_f3,
                           input logic [31:0] i_wd, output int lat, output logic [31:0] o_rd,
                           output logic o_err, output int wen_cnt, output logic [31:0] w_addr,
                           output logic [31:0] w_data);
    lat = -1; o_rd = 'x; o_err = 1'bx; wen_cnt = 0; w_addr = '0; w_data = '0;
    @(negedge clk);
    req = 1'b1; we = i_we; addr = i_addr; funct3 = i_f3; wdata = i_wd;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_wen) begin wen_cnt++; w_addr = mem_addr; w_data = mem_d; end
      if (ready && lat < 0) begin lat = c; o_rd = rdata; o_err = err; end
      if (dbg_state == IDLE) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; funct3 = F3_W; wdata = '0;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", mem_wen); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_word_store();
    int lat, wc; logic [31:0] rd, wa, wd; logic e;
    mem[2] = 32'h0;
    do_access(1'b1, 32'h08, F3_W, 32'hDEADBEEF, lat, rd, e, wc, wa, wd);
    total++; if (lat !== 1) begin bad++; $display("FAIL sw_latency got=%0d exp=1", lat); end
    total++; if (wc !== 1) begin bad++; $display("FAIL sw_wen_cycles got=%0d exp=1", wc); end
    total++; if (wa !== 32'h08) begin bad++; $display("FAIL sw_mem_addr got=%h exp=00000008", wa); end
    total++; if (wd !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem_d got=%h exp=deadbeef", wd); end
    total++; if (rd !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, e); end
    total++; if (mem[2] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[2]); end
  endtask

  task automatic test_sub_store();
    int lat, wc; logic [31:0] rd, wa, wd; logic e;
    mem[2] = 32'h11223344;
    do_access(1'b1, 32'h09, F3_B, 32'h000000AB, lat, rd, e, wc, wa, wd);
    total++; if (lat !== 2) begin bad++; $display("FAIL sb_latency got=%0d exp=2", lat); end
    total++; if (wc !== 1) begin bad++; $display("FAIL sb_wen_cycles got=%0d exp=1", wc); end
    total++; if (mem[2] !== 32'h1122AB44) begin bad++; $display("FAIL sb_mem got=%h exp=1122ab44", mem[2]); end
    total++; if (rd !== 32'h0 || e !== 1'b0) begin bad++; $display("FAIL sb_resp got=%h/%b exp=0/0", rd, e); end
    do_access(1'b1, 32'h0A, F3_H, 32'hFFFF5566, lat, rd, e, wc, wa, wd);
    total++; if (lat !== 2) begin bad++; $display("FAIL sh_latency got=%0d exp=2", lat); end
    total++; if (mem[2] !== 32'h5566AB44) begin bad++; $display("FAIL sh_mem got=%h exp=5566ab44", mem[2]); end
    do_access(1'b1, 32'h0B, F3_B, 32'h00000077, lat, rd, e, wc, wa, wd);
    total++; if (mem[2] !== 32'h7766AB44) begin bad++; $display("FAIL sb3_mem got=%h exp=7766ab44", mem[2]); end
  endtask

  task automatic test_loads();
    logic [31:0] t_addr [7];
    logic [2:0]  t_f3   [7];
    logic [31:0] t_exp  [7];
    int lat, wc; logic [31:0] rd, wa, wd; logic e;
    mem[4] = 32'h80FF7F01;
    t_addr = '{32'h12, 32'h12, 32'h12, 32'h12, 32'h10, 32'h10, 32'h13};
    t_f3   = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_B, F3_B};
    t_exp  = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF,
               32'h80FF7F01, 32'h00000001, 32'hFFFFFF80};
    for (int i = 0; i < 7; i++) begin
      do_access(1'b0, t_addr[i], t_f3[i], 32'h0, lat, rd, e, wc, wa, wd);
      total++;
      if (rd !== t_exp[i] || e !== 1'b0 || lat !== 2 || wc !== 0) begin
        bad++;
        $display("FAIL load_%0d got=%h err=%b lat=%0d wen=%0d exp=%h err=0 lat=2 wen=0",
                 i, rd, e, lat, wc, t_exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic        t_we   [4];
    logic [31:0] t_addr [4];
    logic [2:0]  t_f3   [4];
    int lat, wc; logic [31:0] rd, wa, wd; logic e;
    t_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
    t_addr = '{32'h0A, 32'h03, 32'h08, 32'h10};
    t_f3   = '{F3_W, F3_H, F3_BU, 3'b011};
    mem[2] = 32'h01234567;
    for (int i = 0; i < 4; i++) begin
      do_access(t_we[i], t_addr[i], t_f3[i], 32'hFFFFFFFF, lat, rd, e, wc, wa, wd);
      total++;
      if (e !== 1'b1 || rd !== 32'h0 || lat !== 1 || wc !== 0) begin
        bad++;
        $display("FAIL error_%0d got err=%b rdata=%h lat=%0d wen=%0d exp err=1 rdata=0 lat=1 wen=0",
                 i, e, rd, lat, wc);
      end
    end
    total++; if (mem[2] !== 32'h01234567) begin bad++; $display("FAIL error_mem got=%h exp=01234567", mem[2]); end
  endtask

  task automatic test_reset_abort();
    logic seen;
    mem[1] = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h04; funct3 = F3_H; wdata = 32'h00001234;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dbg_state == WRITE) break;
    end
    total++; if (dbg_state !== WRITE) begin bad++; $display("FAIL abort_reach_write got=%0d exp=2", dbg_state); end
    rst_n = 1'b0;
    #1;
    total++; if (mem_wen !== 1'b0) begin bad++; $display("FAIL abort_wen got=%b exp=0", mem_wen); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b exp=0", ready); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_ready got=%b exp=0", seen); end
    total++; if (mem[1] !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_mem got=%h exp=cafef00d", mem[1]); end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    logic [31:0] exp_v;
    mem[3] = 32'h01020304;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0E; funct3 = F3_HU; wdata = '0;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h00000102);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ready) begin
        pulses.push_back(c);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        total++;
        if (rdata !== exp_v) begin bad++; $display("FAIL b2b_rdata cycle=%0d got=%h exp=%h", c, rdata, exp_v); end
      end
    end
    req = 1'b0;
    total++; if (pulses.size() !== 4) begin bad++; $display("FAIL b2b_pulses got=%0d exp=4", pulses.size()); end
    total++;
    if (pulses.size() == 4 && (pulses[0] !== 2 || pulses[1] !== 5 || pulses[2] !== 8 || pulses[3] !== 11)) begin
      bad++;
      $display("FAIL b2b_spacing got=%0d,%0d,%0d,%0d exp=2,5,8,11", pulses[0], pulses[1], pulses[2], pulses[3]);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_word_store();
    test_sub_store();
    test_loads();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
